// File: rtl/bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// bram_port_arbiter
//
// Shares one 32-bit dual-port block RAM between two bus requesters,
// M0 (CPU data side) and M1 (DMA/loader). One access is accepted per cycle.
// A write drives the RAM write port and a read drives the RAM read-port
// address. The RAM's registered read data is routed back to the requester
// with an rvalid strobe one cycle later.
//
// Arbitration is round-robin on ties. A requester may hold ownership across
// back-to-back beats with its lock input. The hold is bounded to MAX_LOCK
// beats whenever the other requester is waiting.
//
// Parameters
//   ADDR_WIDTH  RAM word-address width (depth = 2**ADDR_WIDTH words)
//   MAX_LOCK    longest locked run before a forced handover (1..255)
//
// Ports
//   clk                  system clock, all state on posedge
//   RSTn                 asynchronous active-low reset
//   mX_req/we/be/lock    request, write flag, byte enables, keep-ownership
//   mX_addr/wdata        byte address (word = addr[ADDR_WIDTH+1:2]), data
//   mX_gnt               access accepted this cycle (combinational)
//   mX_rvalid/rdata      read data strobe one cycle after an accepted read
//   ram_addra/dina/wea   RAM write port
//   ram_addrb/doutb      RAM read port (registered, 1-cycle latency)
// ---------------------------------------------------------------------------
module bram_port_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int MAX_LOCK   = 8
) (
    input  logic                  clk,
    input  logic                  RSTn,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [3:0]            m0_be,
    input  logic                  m0_lock,
    input  logic [ADDR_WIDTH+1:0] m0_addr,
    input  logic [31:0]           m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_rvalid,
    output logic [31:0]           m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [3:0]            m1_be,
    input  logic                  m1_lock,
    input  logic [ADDR_WIDTH+1:0] m1_addr,
    input  logic [31:0]           m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_rvalid,
    output logic [31:0]           m1_rdata,

    output logic [ADDR_WIDTH-1:0] ram_addra,
    output logic [31:0]           ram_dina,
    output logic [3:0]            ram_wea,
    output logic [ADDR_WIDTH-1:0] ram_addrb,
    input  logic [31:0]           ram_doutb
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M0 = 2'd1,
        OWN_M1 = 2'd2
    } state_t;

    localparam logic [8:0] LOCK_LIMIT = 9'(MAX_LOCK);

    state_t     state;
    logic       last_gnt;   // 0: M0 was granted last, 1: M1 was granted last
    logic [7:0] lock_cnt;   // locked beats in the current run, incl. the latest
    logic       rst_done;   // blocks grants until the first edge after reset

    // -----------------------------------------------------------------------
    // Grant decision. Depends only on requests and registered state, so there
    // is no path from ram_doutb to either grant.
    // -----------------------------------------------------------------------
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case/if leaves it unassigned (which would infer a latch).
    always_comb begin
        m0_gnt = 1'b0;
        m1_gnt = 1'b0;
        if (rst_done) begin
            case (state)
                OWN_M0: begin
                    // The owner has priority; if it drops req the other
                    // master is served in the same cycle.
                    if (m0_req) m0_gnt = 1'b1;
                    else        m1_gnt = m1_req;
                end
                OWN_M1: begin
                    if (m1_req) m1_gnt = 1'b1;
                    else        m0_gnt = m0_req;
                end
                default: begin
                    if (m0_req && m1_req) begin
                        m0_gnt = last_gnt;
                        m1_gnt = !last_gnt;
                    end else begin
                        m0_gnt = m0_req;
                        m1_gnt = m1_req;
                    end
                end
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Beat selection: fields of the granted master, M0 when nobody is granted.
    // -----------------------------------------------------------------------
    logic                  acc;
    logic                  acc_we;
    logic                  acc_lock;
    logic [3:0]            acc_be;
    logic [ADDR_WIDTH+1:0] acc_addr;
    logic [31:0]           acc_wdata;
    logic                  other_req;
    logic                  owner_beat;
    logic [8:0]            run_len;
    logic                  at_limit;
    logic [7:0]            cnt_next;
    logic                  unused_ok;

    assign acc       = m0_gnt | m1_gnt;
    assign acc_we    = m1_gnt ? m1_we    : m0_we;
    assign acc_lock  = m1_gnt ? m1_lock  : m0_lock;
    assign acc_be    = m1_gnt ? m1_be    : m0_be;
    assign acc_addr  = m1_gnt ? m1_addr  : m0_addr;
    assign acc_wdata = m1_gnt ? m1_wdata : m0_wdata;
    assign other_req = m1_gnt ? m0_req   : m1_req;

    // The RAM is word addressed; the byte-lane bits are not needed here.
    assign unused_ok = ^acc_addr[1:0];

    assign ram_addra = acc_addr[ADDR_WIDTH+1:2];
    assign ram_addrb = acc_addr[ADDR_WIDTH+1:2];
    assign ram_dina  = acc_wdata;
    assign ram_wea   = (acc && acc_we) ? acc_be : 4'b0000;

    // Read data is only meaningful while rvalid is high, so both requesters
    // see the RAM output directly.
    assign m0_rdata = ram_doutb;
    assign m1_rdata = ram_doutb;

    // Length of the locked run if this beat belongs to it: it extends the
    // current owner's run, or starts a fresh run of one beat.
    assign owner_beat = (state == OWN_M0 && m0_gnt) || (state == OWN_M1 && m1_gnt);
    assign run_len    = owner_beat ? ({1'b0, lock_cnt} + 9'd1) : 9'd1;
    assign at_limit   = (run_len >= LOCK_LIMIT);
    // Saturate so a long run with nobody waiting never wraps.
    assign cnt_next   = at_limit ? LOCK_LIMIT[7:0] : run_len[7:0];

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            last_gnt  <= 1'b1;
            lock_cnt  <= 8'd0;
            rst_done  <= 1'b0;
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
        end else begin
            rst_done  <= 1'b1;
            m0_rvalid <= m0_gnt && !m0_we;
            m1_rvalid <= m1_gnt && !m1_we;

            if (acc) begin
                last_gnt <= m1_gnt;
                // A run that has used its full budget is broken only when the
                // other master is waiting; last_gnt then points at the owner,
                // so the waiting master wins the next tie.
                if (acc_lock && !(at_limit && other_req)) begin
                    state    <= m1_gnt ? OWN_M1 : OWN_M0;
                    lock_cnt <= cnt_next;
                end else begin
                    state    <= IDLE;
                    lock_cnt <= 8'd0;
                end
            end else begin
                // No beat: either nobody asked or the owner let go.
                state    <= IDLE;
                lock_cnt <= 8'd0;
            end
        end
    end

endmodule

// File: tb/tb_bram_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bram_port_arbiter
//
// Directed scenarios with literal expectations, followed by randomized
// traffic. A reference model of the arbitration policy and of the RAM
// contents predicts grants, RAM port values and read returns on every cycle.
// The bench also plays the block RAM that sits on the DUT's RAM ports.
// ---------------------------------------------------------------------------
module tb_bram_port_arbiter;

    localparam int AW    = 12;
    localparam int ML    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          RSTn;

    logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
    logic [3:0]    m0_be;
    logic [AW+1:0] m0_addr;
    logic [31:0]   m0_wdata, m0_rdata;
    logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
    logic [3:0]    m1_be;
    logic [AW+1:0] m1_addr;
    logic [31:0]   m1_wdata, m1_rdata;

    logic [AW-1:0] ram_addra, ram_addrb;
    logic [31:0]   ram_dina, ram_doutb;
    logic [3:0]    ram_wea;

    bram_port_arbiter #(.ADDR_WIDTH(AW), .MAX_LOCK(ML)) dut (
        .clk       (clk),
        .RSTn      (RSTn),
        .m0_req    (m0_req),
        .m0_we     (m0_we),
        .m0_be     (m0_be),
        .m0_lock   (m0_lock),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_rvalid (m0_rvalid),
        .m0_rdata  (m0_rdata),
        .m1_req    (m1_req),
        .m1_we     (m1_we),
        .m1_be     (m1_be),
        .m1_lock   (m1_lock),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_rvalid (m1_rvalid),
        .m1_rdata  (m1_rdata),
        .ram_addra (ram_addra),
        .ram_dina  (ram_dina),
        .ram_wea   (ram_wea),
        .ram_addrb (ram_addrb),
        .ram_doutb (ram_doutb)
    );

    always #5 clk = ~clk;

    // Block RAM attached to the DUT: byte-write port A, registered read port B.
    logic [31:0] ram [0:DEPTH-1];
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++)
            if (ram_wea[b]) ram[ram_addra][8*b +: 8] <= ram_dina[8*b +: 8];
        ram_doutb <= ram[ram_addrb];
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // -----------------------------------------------------------------------
    // Reference model: who must be served this cycle, what the RAM ports must
    // show, and what each requester must get back next cycle.
    // -----------------------------------------------------------------------
    logic [31:0] ref_mem [0:DEPTH-1];
    bit          ready;       // first edge after reset has happened
    int          owner;       // -1 none, else index of the master holding a lock
    int          held;        // beats in the owner's current locked run
    int          last;        // index of the master served most recently
    bit          pend_rv [2];
    logic [31:0] pend_d  [2];

    always @(negedge clk) begin
        bit          req [2];
        bit          we  [2];
        bit          lk  [2];
        logic [3:0]  be  [2];
        int          word[2];
        logic [31:0] wd  [2];
        logic [3:0]  exp_wea;
        int          w;
        int          run;

        req[0] = m0_req;  we[0] = m0_we;  lk[0] = m0_lock;  be[0] = m0_be;
        word[0] = int'(m0_addr >> 2);  wd[0] = m0_wdata;
        req[1] = m1_req;  we[1] = m1_we;  lk[1] = m1_lock;  be[1] = m1_be;
        word[1] = int'(m1_addr >> 2);  wd[1] = m1_wdata;

        if (!RSTn) begin
            check("reset m0_gnt", m0_gnt, 0);
            check("reset m1_gnt", m1_gnt, 0);
            check("reset m0_rvalid", m0_rvalid, 0);
            check("reset m1_rvalid", m1_rvalid, 0);
            check("reset ram_wea", ram_wea, 0);
            ready = 0; owner = -1; held = 0; last = 1;
            pend_rv[0] = 0; pend_rv[1] = 0;
        end else begin
            check("m0_rvalid", m0_rvalid, pend_rv[0]);
            check("m1_rvalid", m1_rvalid, pend_rv[1]);
            if (pend_rv[0]) check("m0_rdata", m0_rdata, pend_d[0]);
            if (pend_rv[1]) check("m1_rdata", m1_rdata, pend_d[1]);

            w = -1;
            if (ready) begin
                if (owner >= 0 && req[owner])  w = owner;
                else if (owner >= 0)           w = req[1-owner] ? 1 - owner : -1;
                else if (req[0] && req[1])     w = 1 - last;
                else if (req[0])               w = 0;
                else if (req[1])               w = 1;
            end

            check("m0_gnt", m0_gnt, (w == 0) ? 1 : 0);
            check("m1_gnt", m1_gnt, (w == 1) ? 1 : 0);
            exp_wea = 4'b0000;
            if (w >= 0) begin
                if (we[w]) exp_wea = be[w];
            end
            check("ram_wea", ram_wea, exp_wea);

            pend_rv[0] = 0; pend_rv[1] = 0;
            if (w >= 0) begin
                if (we[w]) begin
                    check("ram_addra", ram_addra, word[w]);
                    check("ram_dina", ram_dina, wd[w]);
                    for (int b = 0; b < 4; b++)
                        if (be[w][b]) ref_mem[word[w]][8*b +: 8] = wd[w][8*b +: 8];
                end else begin
                    check("ram_addrb", ram_addrb, word[w]);
                    pend_rv[w] = 1;
                    pend_d[w]  = ref_mem[word[w]];
                end
                run  = (owner == w) ? held + 1 : 1;
                last = w;
                if (lk[w] && !(run >= ML && req[1-w])) begin
                    owner = w;
                    held  = (run > ML) ? ML : run;
                end else begin
                    owner = -1;
                    held  = 0;
                end
            end else begin
                owner = -1;
                held  = 0;
            end
            ready = 1;
        end
    end

    // -----------------------------------------------------------------------
    // Stimulus helpers: inputs change 1 time unit after the rising edge.
    // -----------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m0(input bit req, input bit we, input bit lock, input logic [3:0] be,
                          input logic [AW+1:0] addr, input logic [31:0] d);
        m0_req = req; m0_we = we; m0_lock = lock; m0_be = be; m0_addr = addr; m0_wdata = d;
    endtask

    task automatic set_m1(input bit req, input bit we, input bit lock, input logic [3:0] be,
                          input logic [AW+1:0] addr, input logic [31:0] d);
        m1_req = req; m1_we = we; m1_lock = lock; m1_be = be; m1_addr = addr; m1_wdata = d;
    endtask

    task automatic idle_inputs();
        set_m0(0, 0, 0, 4'h0, '0, '0);
        set_m1(0, 0, 0, 4'h0, '0, '0);
    endtask

    task automatic rand_m0();
        set_m0($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 2) == 0,
               4'($urandom), 14'($urandom_range(0, 63)), $urandom);
    endtask

    task automatic rand_m1();
        set_m1($urandom_range(0, 3) != 0, 1'($urandom), $urandom_range(0, 9) < 7,
               4'($urandom), 14'($urandom_range(0, 63)), $urandom);
    endtask

    initial begin
        int          m0_left, m1_left, cyc, run_cnt;
        logic [14:0] seq, busy;
        bit          g0, g1;

        for (int i = 0; i < DEPTH; i++) begin
            ram[i]     = '0;
            ref_mem[i] = '0;
        end
        RSTn = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 RSTn = 1'b1;
        step();

        // 1: write then read back the same word
        set_m0(1, 1, 0, 4'hF, 14'h010, 32'hDEADBEEF);
        @(negedge clk);
        check("t1 write gnt", m0_gnt, 1);
        check("t1 write wea", ram_wea, 4'hF);
        check("t1 write word", ram_addra, 4);
        step();
        set_m0(1, 0, 0, 4'h0, 14'h010, '0);
        @(negedge clk);
        check("t1 read gnt", m0_gnt, 1);
        check("t1 read word", ram_addrb, 4);
        check("t1 read no wea", ram_wea, 0);
        step();
        idle_inputs();
        @(negedge clk);
        check("t1 rvalid", m0_rvalid, 1);
        check("t1 rdata", m0_rdata, 32'hDEADBEEF);
        check("t1 m1 quiet", m1_rvalid, 0);
        step();

        // 2: both reading continuously, strict alternation from M0
        set_m1(1, 1, 0, 4'hF, 14'h100, 32'h0000_0055);
        @(negedge clk);
        check("t2 m1 write gnt", m1_gnt, 1);
        step();
        set_m1(0, 0, 0, 4'h0, '0, '0);
        set_m0(1, 0, 0, 4'h0, 14'h010, '0);
        set_m1(1, 0, 0, 4'h0, 14'h100, '0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("t2 m0_gnt order", m0_gnt, (i % 2 == 0) ? 1 : 0);
            check("t2 m1_gnt order", m1_gnt, (i % 2 == 1) ? 1 : 0);
            if (i > 0) begin
                check("t2 m0_rvalid", m0_rvalid, (i % 2 == 1) ? 1 : 0);
                check("t2 m1_rvalid", m1_rvalid, (i % 2 == 0) ? 1 : 0);
            end
            step();
        end
        idle_inputs();
        @(negedge clk);
        check("t2 last m1_rvalid", m1_rvalid, 1);
        check("t2 last m1_rdata", m1_rdata, 32'h0000_0055);
        check("t2 last m0_rvalid", m0_rvalid, 0);
        step();

        // 3: byte-enable merge
        set_m0(1, 1, 0, 4'hF, 14'h020, 32'h11223344);
        step();
        set_m0(1, 1, 0, 4'b0101, 14'h020, 32'hAABBCCDD);
        @(negedge clk);
        check("t3 partial wea", ram_wea, 4'b0101);
        step();
        set_m0(1, 0, 0, 4'h0, 14'h020, '0);
        step();
        idle_inputs();
        @(negedge clk);
        check("t3 rvalid", m0_rvalid, 1);
        check("t3 merged rdata", m0_rdata, 32'h11BB33DD);
        step();

        // 4: M1 locked burst of 12 reads while M0 keeps requesting
        m1_left = 12; m0_left = 3; cyc = 0; seq = '0; busy = '0;
        while ((m0_left > 0 || m1_left > 0) && cyc < 40) begin
            set_m1(m1_left > 0, 0, m1_left > 1, 4'h0, 14'(32'h200 + 4 * (12 - m1_left)), '0);
            set_m0(cyc >= 1 && m0_left > 0, 0, 0, 4'h0, 14'h010, '0);
            @(negedge clk);
            if (cyc < 15) begin
                seq[cyc]  = m1_gnt;
                busy[cyc] = m0_gnt | m1_gnt;
            end
            if (m0_gnt) m0_left--;
            if (m1_gnt) m1_left--;
            step();
            cyc++;
        end
        idle_inputs();
        check("t4 cycles", cyc, 15);
        check("t4 grant order", seq, 15'b001111011111111);
        check("t4 busy", busy, 15'h7FFF);
        step();

        // 5: locked burst with M0 idle saturates, then release to IDLE
        run_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            set_m1(1, 0, 1, 4'h0, 14'(32'h300 + 4 * i), '0);
            @(negedge clk);
            if (m1_gnt) run_cnt++;
            step();
        end
        check("t5 back-to-back gnts", run_cnt, 12);
        set_m1(1, 0, 0, 4'h0, 14'h300, '0);
        @(negedge clk);
        check("t5 lock_cnt saturated", dut.lock_cnt, 8);
        check("t5 unlock beat gnt", m1_gnt, 1);
        step();
        set_m0(1, 0, 0, 4'h0, 14'h010, '0);
        set_m1(1, 0, 0, 4'h0, 14'h300, '0);
        @(negedge clk);
        check("t5 m0 wins after release", m0_gnt, 1);
        check("t5 m1 waits after release", m1_gnt, 0);
        step();
        idle_inputs();
        step();

        // 6: reset right after an accepted read
        set_m0(1, 0, 0, 4'h0, 14'h010, '0);
        @(negedge clk);
        check("t6 read gnt", m0_gnt, 1);
        @(posedge clk);
        #1 RSTn = 1'b0;
        set_m0(1, 1, 0, 4'hF, 14'h030, 32'h12345678);
        set_m1(1, 0, 0, 4'h0, 14'h100, '0);
        repeat (2) begin
            @(negedge clk);
            check("t6 rvalid dropped", m0_rvalid, 0);
            check("t6 m0_gnt in reset", m0_gnt, 0);
            check("t6 m1_gnt in reset", m1_gnt, 0);
            check("t6 wea in reset", ram_wea, 0);
        end
        @(posedge clk);
        #1 RSTn = 1'b1;
        @(negedge clk);
        check("t6 m0_gnt before first edge", m0_gnt, 0);
        check("t6 m1_gnt before first edge", m1_gnt, 0);
        check("t6 wea before first edge", ram_wea, 0);
        check("t6 rvalid after release", m0_rvalid, 0);
        step();
        @(negedge clk);
        check("t6 m0 wins first tie", m0_gnt, 1);
        check("t6 m1 loses first tie", m1_gnt, 0);
        check("t6 first write wea", ram_wea, 4'hF);
        step();
        idle_inputs();
        step();

        // Randomized traffic; each request is held until it is accepted.
        g0 = 0; g1 = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!m0_req || g0) rand_m0();
            if (!m1_req || g1) rand_m1();
            @(negedge clk);
            g0 = m0_gnt;
            g1 = m1_gnt;
            step();
        end
        idle_inputs();
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
